prpg_seq_ctrl: RTL and testbench
================================

PRPG_SEQ_CTRL -- requirements
Module: prpg_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, PRPG/seed/signature width (min 2).
REQ-002 SHALL have parameter: CNT_W, 8, pattern-count width.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  one-cycle request to run a test session.
REQ-006 SHALL have port: seed  input  WIDTH  PRPG seed, sampled with start.
REQ-007 SHALL have port: num_pat  input  CNT_W  patterns to apply, sampled with start.
REQ-008 SHALL have port: golden  input  WIDTH  expected signature, sampled with start.
REQ-009 SHALL have port: resp  input  WIDTH  circuit response, sampled every RUN cycle.
REQ-010 SHALL have port: prpg_load  output  1  PRPG Load strobe.
REQ-011 SHALL have port: prpg_din  output  WIDTH  seed presented to PRPG.
REQ-012 SHALL have port: prpg_en  output  1  PRPG advance enable.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: pass  output  1  result; held until next accepted start.
REQ-016 SHALL have port: signature  output  WIDTH  current MISR value.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, CHECK, DONE.
REQ-018 SHALL, in IDLE, on start=1 latch seed/num_pat/golden, clear pass, and enter LOAD.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL, in LOAD (exactly 1 cycle), drive prpg_load=1 and prpg_din=latched seed, clear MISR to 0 and the pattern counter to 0.
REQ-021 SHALL transition LOAD->RUN if latched num_pat!=0, else LOAD->CHECK.
REQ-022 SHALL, in RUN, drive prpg_en=1, increment the counter each cycle, and leave after exactly num_pat cycles (to CHECK).
REQ-023 SHALL update MISR on each RUN cycle: sig <= {sig[WIDTH-2:0], sig[WIDTH-1]^sig[WIDTH-2]} ^ resp; MISR holds in all other states except LOAD.
REQ-024 SHALL, in CHECK (1 cycle), register pass <= (sig == latched golden), then enter DONE.
REQ-025 SHALL, in DONE (1 cycle), assert done=1, then return to IDLE.
REQ-026 SHALL have start-accept-edge to done-high latency of num_pat+3 cycles (num_pat=0: 3 cycles).
REQ-027 SHALL drive prpg_load=0 and prpg_en=0 outside LOAD/RUN; prpg_din=latched seed at all times.
REQ-028 SHALL allow start asserted in the cycle after DONE to be accepted normally (back-to-back sessions).
REQ-029 SHALL count without overflow for num_pat = 2^CNT_W-1 (counter compares, never wraps past num_pat).

Reset
REQ-030 SHALL, on rst=1, immediately force state IDLE and set busy, done, pass, prpg_load, prpg_en, signature, counter and latched registers to 0.
REQ-031 SHALL abandon a session in progress on rst (no done pulse), resuming in IDLE after rst deasserts.

Configuration
REQ-032 SHALL, with PRPG_ABORT_EN defined, add port abort (input, 1): abort=1 in LOAD or RUN moves to IDLE next edge, prpg_en/prpg_load drop to 0, done is not pulsed, and pass stays 0; abort is ignored in other states.
REQ-033 SHALL, without PRPG_ABORT_EN, have no abort port and run every accepted session to DONE.

Verification
REQ-034 SHALL verify: reset, then seed=4'h4, num_pat=0, golden=0 -> prpg_load one cycle, no prpg_en, done 3 cycles after start, pass=1, signature=0.
REQ-035 SHALL verify: num_pat=2, resp=4'b0001 constant, golden=4'b0011 -> prpg_en high exactly 2 cycles, signature=4'b0011, pass=1, done at start+5.
REQ-036 SHALL verify: same as REQ-035 with golden=4'b0010 -> pass=0, done still pulses once.
REQ-037 SHALL verify: start re-asserted during RUN with num_pat=5 -> ignored; single done at start+8; start in cycle after DONE -> new session accepted.
REQ-038 SHALL verify: rst asserted mid-RUN -> outputs 0 within same cycle (asynchronous), no done; fresh session afterwards passes.
REQ-039 SHALL verify (PRPG_ABORT_EN): abort in 2nd RUN cycle -> IDLE next edge, prpg_en=0, done never asserted, pass=0.

Source files
------------

// File: rtl/prpg_seq_ctrl.sv
// PRPG/MISR BIST session sequencer: load seed, run num_pat patterns, compact responses, compare.
// Optional abort input is added when PRPG_ABORT_EN is defined.
module prpg_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PRPG_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] num_pat,
   input  logic [WIDTH-1:0] golden,
   input  logic [WIDTH-1:0] resp,
   output logic             prpg_load,
   output logic [WIDTH-1:0] prpg_din,
   output logic             prpg_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] gold_q, gold_d;
   logic [CNT_W-1:0] npat_q, npat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic             pass_q, pass_d;
   logic             abort_w;
   logic [WIDTH-1:0] misr_next;
   logic             last_pat;

`ifdef PRPG_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign misr_next = {sig_q[WIDTH-2:0], sig_q[WIDTH-1] ^ sig_q[WIDTH-2]} ^ resp;
   // Compare against num_pat-1 so a full-scale count never wraps the counter.
   assign last_pat  = (cnt_q == npat_q - CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      gold_d    = gold_q;
      npat_d    = npat_q;
      cnt_d     = cnt_q;
      sig_d     = sig_q;
      pass_d    = pass_q;
      prpg_load = 1'b0;
      prpg_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               seed_d  = seed;
               gold_d  = golden;
               npat_d  = num_pat;
               pass_d  = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            prpg_load = 1'b1;
            sig_d     = '0;
            cnt_d     = '0;
            state_d   = (npat_q != '0) ? RUN : CHECK;
            if (abort_w) state_d = IDLE;
         end
         RUN: begin
            prpg_en = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            sig_d   = misr_next;
            if (last_pat) state_d = CHECK;
            if (abort_w)  state_d = IDLE;
         end
         CHECK: begin
            pass_d  = (sig_q == gold_q);
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         seed_q  <= '0;
         gold_q  <= '0;
         npat_q  <= '0;
         cnt_q   <= '0;
         sig_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         gold_q  <= gold_d;
         npat_q  <= npat_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
         pass_q  <= pass_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign prpg_din  = seed_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_prpg_seq_ctrl.sv
// Directed bench for prpg_seq_ctrl: vector table of sessions plus reset/start/abort corner sequences.
module tb_prpg_seq_ctrl;

   typedef struct {
      logic [3:0] seed;
      logic [7:0] npat;
      logic [3:0] golden;
      logic [3:0] resp;
      logic [3:0] exp_sig;
      logic       exp_pass;
   } vec_t;

   logic       clk, rst, start;
   logic [3:0] seed, golden, resp;
   logic [7:0] num_pat;
   logic       prpg_load, prpg_en, busy, done, pass;
   logic [3:0] prpg_din, signature;
`ifdef PRPG_ABORT_EN
   logic       abort;
`endif

   int tests = 0;
   int fails = 0;
   vec_t vecs[10];

   prpg_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
`ifdef PRPG_ABORT_EN
      .abort(abort),
`endif
      .start(start), .seed(seed), .num_pat(num_pat), .golden(golden), .resp(resp),
      .prpg_load(prpg_load), .prpg_din(prpg_din), .prpg_en(prpg_en),
      .busy(busy), .done(done), .pass(pass), .signature(signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One full session; returns at the DONE cycle. inj_cyc>0 raises a stray start in that cycle.
   task automatic run_session(input string tag, input vec_t v, input int inj_cyc);
      int   cyc, nload, nen;
      logic seen;
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_done"}, done, 0);
      seed = v.seed; num_pat = v.npat; golden = v.golden; resp = v.resp; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nload = 0; nen = 0; seen = 1'b0;
      chk({tag, "_pass_clr"}, pass, 0);
      chk({tag, "_din"}, prpg_din, v.seed);
      while (cyc <= 400) begin
         if (prpg_load) nload++;
         if (prpg_en)   nen++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (cyc == inj_cyc) begin
            start = 1'b1; seed = ~v.seed; num_pat = 8'd1; golden = ~v.golden;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_latency"}, cyc, v.npat + 3);
      chk({tag, "_load_cycles"}, nload, 1);
      chk({tag, "_en_cycles"}, nen, v.npat);
      chk({tag, "_sig"}, signature, v.exp_sig);
      chk({tag, "_pass"}, pass, v.exp_pass);
      chk({tag, "_din_hold"}, prpg_din, v.seed);
   endtask

   task automatic no_done_for(input string tag, input int n);
      int cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk({tag, "_no_done"}, cnt, 0);
   endtask

   initial begin
      //           seed   npat    golden resp   sig    pass
      vecs[0] = '{4'h4, 8'd0,   4'h0, 4'h0, 4'h0, 1'b1};
      vecs[1] = '{4'h9, 8'd2,   4'h3, 4'h1, 4'h3, 1'b1};
      vecs[2] = '{4'h9, 8'd2,   4'h2, 4'h1, 4'h3, 1'b0};
      vecs[3] = '{4'h5, 8'd3,   4'h7, 4'h1, 4'h7, 1'b1};
      vecs[4] = '{4'hC, 8'd1,   4'hA, 4'hA, 4'hA, 1'b1};
      vecs[5] = '{4'h6, 8'd4,   4'hE, 4'h1, 4'hE, 1'b1};
      vecs[6] = '{4'h3, 8'd5,   4'hD, 4'h1, 4'hD, 1'b1};
      vecs[7] = '{4'hF, 8'd4,   4'h0, 4'h0, 4'h0, 1'b1};
      vecs[8] = '{4'h1, 8'd255, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[9] = '{4'h2, 8'd1,   4'h4, 4'h5, 4'h5, 1'b0};

      rst = 1'b1; start = 1'b0; seed = '0; num_pat = '0; golden = '0; resp = '0;
`ifdef PRPG_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_load", prpg_load, 0);
      chk("rst_en", prpg_en, 0);
      chk("rst_sig", signature, 0);
      chk("rst_din", prpg_din, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_session($sformatf("v%0d", i), vecs[i], 0);

      // Stray start during RUN is ignored; start right after DONE is accepted.
      run_session("inj", '{4'hA, 8'd5, 4'hD, 4'h1, 4'hD, 1'b1}, 3);
      run_session("b2b", vecs[1], 0);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      seed = 4'h7; num_pat = 8'd5; resp = 4'h1; golden = 4'hD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_en", prpg_en, 1);
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_en", prpg_en, 0);
      chk("mid_load", prpg_load, 0);
      chk("mid_sig", signature, 0);
      chk("mid_done", done, 0);
      chk("mid_din", prpg_din, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      no_done_for("mid", 12);
      run_session("post_rst", vecs[1], 0);

`ifdef PRPG_ABORT_EN
      @(negedge clk);
      seed = 4'h3; num_pat = 8'd5; resp = 4'h1; golden = 4'h0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abt_pre_en", prpg_en, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abt_busy", busy, 0);
      chk("abt_en", prpg_en, 0);
      chk("abt_load", prpg_load, 0);
      no_done_for("abt", 10);
      chk("abt_pass", pass, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
